// File: rtl/rom_loader.sv
// rom_loader: packs a little-endian byte stream into WIDTH-bit words and
// writes them to a DEPTH-entry memory at sequential, wrapping addresses
// starting from a base address latched on start.
module rom_loader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] base_addr,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     we,
  output logic [$clog2(DEPTH)-1:0] waddr,
  output logic [WIDTH-1:0]         wdata,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned ADDRW = $clog2(DEPTH);
  localparam int unsigned CNTW  = ADDRW + 1;
  localparam int unsigned BPW   = (WIDTH + 7) / 8;
  localparam int unsigned BUFW  = BPW * 8;
  localparam int unsigned IDXW  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [CNTW-1:0]  len_q, len_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [BUFW-1:0]  buf_q, buf_d;
  logic             s_ready_q, s_ready_d;
  logic             we_q, we_d;
  logic [ADDRW-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BUFW-1:0]  buf_new;
  logic [ADDRW-1:0] addr_next;
  logic [CNTW-1:0]  cnt_next;

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      buf_q     <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      s_ready_q <= s_ready_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so each one is a flop that reflects the state being entered.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    s_ready_d = 1'b0;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;

    buf_new                = buf_q;
    buf_new[8*idx_q +: 8]  = s_data;
    addr_next = (addr_q == ADDRW'(DEPTH - 1)) ? '0 : addr_q + ADDRW'(1);
    cnt_next  = cnt_q + CNTW'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_d    = base_addr;
            len_d     = len;
            cnt_d     = '0;
            idx_d     = '0;
            buf_d     = '0;
            s_ready_d = 1'b1;
            state_d   = COLLECT;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      COLLECT: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready_q) begin
          buf_d = buf_new;
          if (idx_q == IDXW'(BPW - 1)) begin
            s_ready_d = 1'b0;
            we_d      = 1'b1;
            waddr_d   = addr_q;
            wdata_d   = buf_new[WIDTH-1:0];
            state_d   = WRITE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end

      WRITE: begin
        addr_d = addr_next;
        cnt_d  = cnt_next;
        if (cnt_next == len_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d     = '0;
          buf_d     = '0;
          s_ready_d = 1'b1;
          state_d   = COLLECT;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign s_ready = s_ready_q;
  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: drives three loader instances (WIDTH 8/12/16) from shared
// stimulus, compares the selected instance's writes against a queue of
// expected (address, data) pairs and checks done timing.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  len;
  logic [7:0]  s_data;
  logic        s_valid;
  logic [1:0]  sel;

  logic        rdy8, we8, busy8, done8;
  logic [7:0]  waddr8;
  logic [7:0]  wdata8;
  logic        rdy12, we12, busy12, done12;
  logic [7:0]  waddr12;
  logic [11:0] wdata12;
  logic        rdy16, we16, busy16, done16;
  logic [7:0]  waddr16;
  logic [15:0] wdata16;

  logic        s_ready_m, we_m, busy_m, done_m;
  logic [7:0]  waddr_m;
  logic [31:0] wdata_m;

  always #5 clk = ~clk;

  rom_loader #(.WIDTH(8), .DEPTH(256)) u_w8 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy8), .we(we8),
    .waddr(waddr8), .wdata(wdata8), .busy(busy8), .done(done8));

  rom_loader #(.WIDTH(12), .DEPTH(256)) u_w12 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy12), .we(we12),
    .waddr(waddr12), .wdata(wdata12), .busy(busy12), .done(done12));

  rom_loader #(.WIDTH(16), .DEPTH(256)) u_w16 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy16), .we(we16),
    .waddr(waddr16), .wdata(wdata16), .busy(busy16), .done(done16));

  assign s_ready_m = (sel == 2'd0) ? rdy8   : (sel == 2'd1) ? rdy12   : rdy16;
  assign we_m      = (sel == 2'd0) ? we8    : (sel == 2'd1) ? we12    : we16;
  assign busy_m    = (sel == 2'd0) ? busy8  : (sel == 2'd1) ? busy12  : busy16;
  assign done_m    = (sel == 2'd0) ? done8  : (sel == 2'd1) ? done12  : done16;
  assign waddr_m   = (sel == 2'd0) ? waddr8 : (sel == 2'd1) ? waddr12 : waddr16;
  assign wdata_m   = (sel == 2'd0) ? 32'(wdata8) :
                     (sel == 2'd1) ? 32'(wdata12) : 32'(wdata16);

  typedef struct packed {
    logic [1:0]        sel;
    logic [7:0]        base;
    logic [8:0]        len;
    logic [3:0]        nb;
    logic [7:0][7:0]   b;
    logic [3:0][7:0]   ea;
    logic [3:0][31:0]  ed;
    logic [15:0]       lat;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_cnt = 0;
  logic [39:0] expq[$];
  logic [7:0]  txq[$];
  vec_t        vecs[6];

  function automatic vec_t mk(input logic [1:0] s, input logic [7:0] ba,
                              input logic [8:0] l, input logic [3:0] n,
                              input logic [63:0] bytes, input logic [31:0] addrs,
                              input logic [127:0] datas, input logic [15:0] lt);
    vec_t v;
    v.sel = s; v.base = ba; v.len = l; v.nb = n;
    v.b = bytes; v.ea = addrs; v.ed = datas; v.lat = lt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock step, sampled on the falling edge; scoreboards any write.
  task automatic tick();
    logic [39:0] e;
    @(negedge clk);
    cyc++;
    if (we_m) begin
      check("s_ready_during_write", 32'(s_ready_m), 32'd0);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                 waddr_m, wdata_m);
      end else begin
        e = expq.pop_front();
        check("waddr", 32'(waddr_m), 32'(e[39:32]));
        check("wdata", wdata_m, e[31:0]);
      end
    end
    if (done_m) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_m) busy_cnt++;
  endtask

  task automatic reset_all();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0;
    tick();
    rst = 1'b0;
    expq.delete();
    txq.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    base_addr = b; len = l; start = 1'b1;
    start_cyc = cyc; done_cnt = 0; busy_cnt = 0;
    tick();
    start = 1'b0;
  endtask

  // Feeds txq; bubble inserts two idle cycles after each accepted byte,
  // poke >= 0 pulses a stray start with other parameters at that step.
  task automatic send(input bit bubble, input int poke);
    int g = 0;
    int gap = 0;
    while (txq.size() != 0 && g < 3000) begin
      if (gap > 0) begin
        s_valid = 1'b0; gap--;
      end else begin
        s_valid = 1'b1; s_data = txq[0];
      end
      if (poke >= 0 && g == poke) begin
        start = 1'b1; base_addr = 8'h99; len = 9'd1;
      end else begin
        start = 1'b0;
      end
      if (s_valid && s_ready_m) begin
        void'(txq.pop_front());
        if (bubble) gap = 2;
      end
      tick();
      g++;
    end
    s_valid = 1'b0;
    start = 1'b0;
    if (txq.size() != 0) check("bytes_accepted_timeout", 32'(txq.size()), 32'd0);
  endtask

  task automatic finish_load(input string name, input int lat);
    int g = 0;
    while (done_cnt == 0 && g < 2000) begin
      tick();
      g++;
    end
    for (int i = 0; i < 4; i++) tick();
    check({name, "_done_count"}, 32'(done_cnt), 32'd1);
    check({name, "_writes_left"}, 32'(expq.size()), 32'd0);
    if (lat > 0) check({name, "_done_latency"}, 32'(done_cyc - start_cyc), 32'(lat));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    s_data = '0; s_valid = 1'b0; sel = 2'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state of every instance.
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("rst_s_ready", 32'(s_ready_m), 32'd0);
      check("rst_we", 32'(we_m), 32'd0);
      check("rst_busy", 32'(busy_m), 32'd0);
      check("rst_done", 32'(done_m), 32'd0);
      check("rst_waddr", 32'(waddr_m), 32'd0);
      check("rst_wdata", wdata_m, 32'd0);
    end

    vecs[0] = mk(2'd0, 8'h10, 9'd4, 4'd4, 64'hD4C3B2A1, 32'h13121110,
                 128'h000000D4_000000C3_000000B2_000000A1, 16'd9);
    vecs[1] = mk(2'd1, 8'h00, 9'd1, 4'd2, 64'hF534, 32'h00000000,
                 128'h00000534, 16'd4);
    vecs[2] = mk(2'd0, 8'hFE, 9'd3, 4'd3, 64'h030201, 32'h0000FFFE,
                 128'h00000000_00000003_00000002_00000001, 16'd7);
    vecs[3] = mk(2'd2, 8'h40, 9'd2, 4'd4, 64'h44332211, 32'h00004140,
                 128'h00000000_00000000_00004433_00002211, 16'd7);
    vecs[4] = mk(2'd2, 8'h55, 9'd0, 4'd0, 64'h0, 32'h0, 128'h0, 16'd1);
    vecs[5] = mk(2'd1, 8'h7F, 9'd2, 4'd4, 64'hFDEF9ABC, 32'h0000807F,
                 128'h00000000_00000000_00000DEF_00000ABC, 16'd7);

    // Table: s_valid held high throughout each load.
    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].sel;
      reset_all();
      do_start(vecs[v].base, vecs[v].len);
      for (int k = 0; k < 32'(vecs[v].len); k++)
        expq.push_back({vecs[v].ea[k], vecs[v].ed[k]});
      for (int k = 0; k < 32'(vecs[v].nb); k++) txq.push_back(vecs[v].b[k]);
      send(1'b0, -1);
      finish_load($sformatf("vec%0d", v), 32'(vecs[v].lat));
      if (vecs[v].len == 9'd0) check("zero_len_busy_cycles", 32'(busy_cnt), 32'd1);
    end

    // Bubbles on s_valid plus a stray start while busy.
    sel = 2'd2;
    reset_all();
    do_start(8'h60, 9'd2);
    expq.push_back({8'h60, 32'h2211});
    expq.push_back({8'h61, 32'h4433});
    txq.push_back(8'h11); txq.push_back(8'h22);
    txq.push_back(8'h33); txq.push_back(8'h44);
    send(1'b1, 3);
    finish_load("bubbles", 0);

    // Reset in the middle of a word: partial data discarded, no write.
    sel = 2'd2;
    reset_all();
    do_start(8'h20, 9'd2);
    s_valid = 1'b1; s_data = 8'hAB;
    tick();
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_s_ready", 32'(s_ready_m), 32'd0);
    check("midrst_we", 32'(we_m), 32'd0);
    check("midrst_busy", 32'(busy_m), 32'd0);
    check("midrst_done", 32'(done_m), 32'd0);
    check("midrst_waddr", 32'(waddr_m), 32'd0);
    check("midrst_wdata", wdata_m, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    do_start(8'h30, 9'd1);
    expq.push_back({8'h30, 32'h6655});
    txq.push_back(8'h55); txq.push_back(8'h66);
    send(1'b0, -1);
    finish_load("after_reset", 4);

    // Full-depth load from a non-zero base wraps over every address once.
    sel = 2'd0;
    reset_all();
    do_start(8'h80, 9'd256);
    for (int k = 0; k < 256; k++) begin
      expq.push_back({8'(8'h80 + k), 32'(k ^ 8'h5A)});
      txq.push_back(8'(k ^ 8'h5A));
    end
    send(1'b0, -1);
    finish_load("full_depth", 513);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
